// File: rtl/logic_shift_unit_if.sv
// Request/response bundle for the logical/shift execution unit.
// master = issuing stage plus result consumer, slave = logic_shift_unit.
interface logic_shift_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] y;
    logic            illegal;

    modport master (
        output in_valid, a, b, opcode, func3, func7, out_ready,
        input  in_ready, out_valid, y, illegal
    );

    modport slave (
        input  in_valid, a, b, opcode, func3, func7, out_ready,
        output in_ready, out_valid, y, illegal
    );
endinterface

// File: rtl/logic_shift_unit.sv
// RV logical/shift unit (optional Zbb ANDN/ORN/XNOR); latency 1 cycle, or 1+ceil(shamt/SHIFT_STEP) for shifts.
// One op in flight: in_ready only in IDLE; out_ready low holds y/illegal/out_valid stable indefinitely.
module logic_shift_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter bit ZBB_EN     = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    logic_shift_unit_if.slave bus
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state;
    logic [XLEN-1:0] work;
    logic [CW-1:0]   cnt;
    logic            sh_left;
    logic            sh_arith;
    logic [XLEN-1:0] y_q;
    logic            ill_q;
    logic            ov_q;

    logic            is_r;
    logic            is_i;
    logic [6:0]      f7chk;
    logic            dec_illegal;
    logic            dec_shift;
    logic            dec_left;
    logic            dec_arith;
    logic            dec_inv;
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] bb;
    logic [XLEN-1:0] lres;
    logic [XLEN-1:0] acc_val;
    logic [CW-1:0]   step;
    logic [XLEN-1:0] shifted;
    logic signed [XLEN-1:0] work_s;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = ov_q;
    assign bus.y         = y_q;
    assign bus.illegal   = ill_q;

    assign is_r  = (bus.opcode == OP_R);
    assign is_i  = (bus.opcode == OP_I);
    assign shamt = bus.b[SW-1:0];
    // On RV64 the I-form shamt[5] lives in func7[0], so it must not fail the zero check.
    assign f7chk = (is_i && XLEN == 64) ? {bus.func7[6:1], 1'b0} : bus.func7;

    always_comb begin
        dec_illegal = 1'b1;
        dec_shift   = 1'b0;
        dec_left    = 1'b0;
        dec_arith   = 1'b0;
        dec_inv     = 1'b0;
        if (is_r || is_i) begin
            case (bus.func3)
                3'b100, 3'b110, 3'b111: begin
                    if (is_i || bus.func7 == 7'b0000000) begin
                        dec_illegal = 1'b0;
                    end else if (ZBB_EN && bus.func7 == 7'b0100000) begin
                        dec_illegal = 1'b0;
                        dec_inv     = 1'b1;
                    end
                end
                3'b001: begin
                    if (f7chk == 7'b0000000) begin
                        dec_illegal = 1'b0;
                        dec_shift   = 1'b1;
                        dec_left    = 1'b1;
                    end
                end
                3'b101: begin
                    if ((f7chk & 7'b1011111) == 7'b0000000) begin
                        dec_illegal = 1'b0;
                        dec_shift   = 1'b1;
                        dec_arith   = bus.func7[5];
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // ~(a^b) == a^~b, so the Zbb forms only need b inverted.
    assign bb = dec_inv ? ~bus.b : bus.b;

    always_comb begin
        case (bus.func3)
            3'b100:  lres = bus.a ^ bb;
            3'b110:  lres = bus.a | bb;
            default: lres = bus.a & bb;
        endcase
    end

    assign acc_val = dec_illegal ? '0 : (dec_shift ? bus.a : lres);

    assign step   = (cnt > STEP_C) ? STEP_C : cnt;
    assign work_s = work;

    always_comb begin
        if (sh_left) begin
            shifted = work << step;
        end else if (sh_arith) begin
            shifted = work_s >>> step;
        end else begin
            shifted = work >> step;
        end
    end

    // Every op passes through SHIFT (cnt=0 for non-shifts) so the result is registered one edge after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            cnt      <= '0;
            sh_left  <= 1'b0;
            sh_arith <= 1'b0;
            y_q      <= '0;
            ill_q    <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work     <= acc_val;
                        cnt      <= dec_shift ? CW'(shamt) : '0;
                        sh_left  <= dec_left;
                        sh_arith <= dec_arith;
                        ill_q    <= dec_illegal;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        y_q   <= work;
                        ov_q  <= 1'b1;
                        state <= DONE;
                    end else begin
                        work <= shifted;
                        cnt  <= cnt - step;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ov_q  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_logic_shift_unit.sv
// Directed bench for logic_shift_unit: three configurations share one stimulus bus,
// and each vector names the instance whose response is checked.
module tb_logic_shift_unit;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef struct {
        int          sel;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] y;
        logic        ill;
        int          lat;
        string       name;
    } vec_t;

    localparam int NV = 21;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [6:0]  opcode;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic [63:0] a_in;
    logic [63:0] b_in;
    int          sel;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_ill;
    logic [63:0] s_y;
    int          tests = 0;
    int          fails = 0;
    vec_t        tbl [NV];

    always #5 clk = ~clk;

    logic_shift_unit_if #(.XLEN(32)) if0 ();
    logic_shift_unit_if #(.XLEN(32)) if1 ();
    logic_shift_unit_if #(.XLEN(64)) if2 ();

    assign if0.in_valid = in_valid;  assign if0.out_ready = out_ready;
    assign if0.a = a_in[31:0];       assign if0.b = b_in[31:0];
    assign if0.opcode = opcode;      assign if0.func3 = func3;  assign if0.func7 = func7;
    assign if1.in_valid = in_valid;  assign if1.out_ready = out_ready;
    assign if1.a = a_in[31:0];       assign if1.b = b_in[31:0];
    assign if1.opcode = opcode;      assign if1.func3 = func3;  assign if1.func7 = func7;
    assign if2.in_valid = in_valid;  assign if2.out_ready = out_ready;
    assign if2.a = a_in;             assign if2.b = b_in;
    assign if2.opcode = opcode;      assign if2.func3 = func3;  assign if2.func7 = func7;

    logic_shift_unit #(.XLEN(32), .SHIFT_STEP(1), .ZBB_EN(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    logic_shift_unit #(.XLEN(32), .SHIFT_STEP(8), .ZBB_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    logic_shift_unit #(.XLEN(64), .SHIFT_STEP(4), .ZBB_EN(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always_comb begin
        case (sel)
            1: begin
                s_in_ready = if1.in_ready; s_out_valid = if1.out_valid;
                s_y = {32'h0, if1.y};      s_ill = if1.illegal;
            end
            2: begin
                s_in_ready = if2.in_ready; s_out_valid = if2.out_valid;
                s_y = if2.y;               s_ill = if2.illegal;
            end
            default: begin
                s_in_ready = if0.in_ready; s_out_valid = if0.out_valid;
                s_y = {32'h0, if0.y};      s_ill = if0.illegal;
            end
        endcase
    end

    task automatic check(input string name, input string field, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h, expected %h", name, field, act, exp);
        end
    endtask

    task automatic start_op(input int s, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [63:0] av, input logic [63:0] bv);
        int guard = 0;
        sel = s;
        @(negedge clk);
        opcode = op; func3 = f3; func7 = f7; a_in = av; b_in = bv;
        in_valid = 1'b1;
        while (!s_in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            tests++;
            fails++;
            $display("FAIL accept: in_ready never rose on dut%0d", s);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic do_op(input int s, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] av, input logic [63:0] bv,
                         output logic [63:0] ry, output logic ri, output int lat);
        start_op(s, op, f3, f7, av, bv);
        lat = 0;
        while (!s_out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        ry = s_y;
        ri = s_ill;
    endtask

    initial begin
        logic [63:0] ry;
        logic        ri;
        int          lat;

        tbl[0]  = '{0, OP_R, 3'b111, 7'h00, 64'hAAAAFFFF, 64'h0F0F0F0F, 64'h0A0A0F0F, 1'b0, 1, "and"};
        tbl[1]  = '{0, OP_R, 3'b110, 7'h00, 64'hAAAAFFFF, 64'h0F0F0F0F, 64'hAFAFFFFF, 1'b0, 1, "or"};
        tbl[2]  = '{0, OP_R, 3'b100, 7'h00, 64'hAAAAFFFF, 64'h0F0F0F0F, 64'hA5A5F0F0, 1'b0, 1, "xor"};
        tbl[3]  = '{0, OP_I, 3'b100, 7'h07, 64'hAAAAFFFF, 64'hFFFFF0F0, 64'h55550F0F, 1'b0, 1, "xori"};
        tbl[4]  = '{0, OP_I, 3'b101, 7'h20, 64'h80000000, 64'h0000041F, 64'hFFFFFFFF, 1'b0, 32, "srai_s1"};
        tbl[5]  = '{0, OP_I, 3'b101, 7'h00, 64'h80000000, 64'h0000001F, 64'h00000001, 1'b0, 32, "srli_s1"};
        tbl[6]  = '{0, OP_R, 3'b001, 7'h00, 64'h12345678, 64'h00000000, 64'h12345678, 1'b0, 1, "sll0"};
        tbl[7]  = '{0, OP_R, 3'b001, 7'h00, 64'h12345678, 64'hFFFFFFE4, 64'h23456780, 1'b0, 5, "sll4"};
        tbl[8]  = '{0, OP_R, 3'b101, 7'h20, 64'hF0000000, 64'h00000004, 64'hFF000000, 1'b0, 5, "sra4"};
        tbl[9]  = '{0, 7'b0000011, 3'b010, 7'h00, 64'h12345678, 64'h4, 64'h0, 1'b1, 1, "load_op"};
        tbl[10] = '{0, OP_R, 3'b001, 7'h01, 64'h1, 64'h1, 64'h0, 1'b1, 1, "sll_f7"};
        tbl[11] = '{0, OP_R, 3'b111, 7'h20, 64'hFFFF0000, 64'h0F0F0F0F, 64'h0, 1'b1, 1, "andn_nozbb"};
        tbl[12] = '{0, OP_R, 3'b000, 7'h00, 64'h1, 64'h1, 64'h0, 1'b1, 1, "add_op"};
        tbl[13] = '{1, OP_I, 3'b101, 7'h20, 64'h80000000, 64'h0000041F, 64'hFFFFFFFF, 1'b0, 5, "srai_s8"};
        tbl[14] = '{1, OP_R, 3'b111, 7'h20, 64'hFFFF0000, 64'h0F0F0F0F, 64'hF0F00000, 1'b0, 1, "andn"};
        tbl[15] = '{1, OP_R, 3'b110, 7'h20, 64'hFFFF0000, 64'h0F0F0F0F, 64'hFFFFF0F0, 1'b0, 1, "orn"};
        tbl[16] = '{1, OP_R, 3'b100, 7'h20, 64'hFFFF0000, 64'h0F0F0F0F, 64'h0F0FF0F0, 1'b0, 1, "xnor"};
        tbl[17] = '{1, OP_R, 3'b001, 7'h00, 64'h1, 64'h9, 64'h200, 1'b0, 3, "sll9_s8"};
        tbl[18] = '{2, OP_I, 3'b001, 7'h01, 64'h1, 64'h3F, 64'h8000000000000000, 1'b0, 17, "slli63_x64"};
        tbl[19] = '{2, OP_I, 3'b101, 7'h21, 64'h8000000000000000, 64'h420, 64'hFFFFFFFF80000000, 1'b0, 9, "srai32_x64"};
        tbl[20] = '{2, OP_R, 3'b111, 7'h00, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'h0F0F00000F0F0000, 1'b0, 1, "and_x64"};

        sel = 0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; func3 = '0; func7 = '0; a_in = '0; b_in = '0;
        #2;
        check("reset", "out_valid", 64'(s_out_valid), 64'h0);
        check("reset", "y", s_y, 64'h0);
        check("reset", "illegal", 64'(s_ill), 64'h0);
        #18 rst_n = 1'b1;
        #1 check("reset", "in_ready", 64'(s_in_ready), 64'h1);

        for (int i = 0; i < NV; i++) begin
            do_op(tbl[i].sel, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].a, tbl[i].b, ry, ri, lat);
            check(tbl[i].name, "y", ry, tbl[i].y);
            check(tbl[i].name, "illegal", 64'(ri), 64'(tbl[i].ill));
            check(tbl[i].name, "latency", 64'(lat), 64'(tbl[i].lat));
        end

        // Result stalled in DONE: outputs frozen, new request refused.
        out_ready = 1'b0;
        do_op(1, OP_R, 3'b111, 7'h00, 64'hAAAAFFFF, 64'h0F0F0F0F, ry, ri, lat);
        check("stall", "y", ry, 64'h0A0A0F0F);
        in_valid = 1'b1; opcode = OP_R; func3 = 3'b110; func7 = 7'h00;
        a_in = 64'hFFFFFFFF; b_in = 64'h0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("stall", "y_held", s_y, 64'h0A0A0F0F);
            check("stall", "out_valid_held", 64'(s_out_valid), 64'h1);
            check("stall", "in_ready_low", 64'(s_in_ready), 64'h0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release", "out_valid", 64'(s_out_valid), 64'h0);
        check("stall_release", "in_ready", 64'(s_in_ready), 64'h1);
        @(posedge clk);
        #1;
        check("stall_release", "no_ghost_op", 64'(s_in_ready), 64'h1);

        // Reset in the middle of a long shift.
        do_op(0, OP_R, 3'b100, 7'h00, 64'hAAAAFFFF, 64'h0F0F0F0F, ry, ri, lat);
        check("pre_reset", "y", ry, 64'hA5A5F0F0);
        start_op(0, OP_I, 3'b101, 7'h20, 64'h80000000, 64'h0000041F);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset", "out_valid", 64'(s_out_valid), 64'h0);
        check("mid_reset", "y", s_y, 64'h0);
        check("mid_reset", "in_ready", 64'(s_in_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, OP_I, 3'b101, 7'h00, 64'hF0000000, 64'h4, ry, ri, lat);
        check("post_reset", "y", ry, 64'h0F000000);
        check("post_reset", "latency", 64'(lat), 64'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
